// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_pkg
// Description : Shared AES types, FSM encoding and GF(2^8) helper for the
//               decryption round datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

    // Low byte of the AES reduction polynomial x^8 + x^4 + x^3 + x + 1
    localparam logic [7:0] GF_POLY = 8'h1B;

    typedef logic [7:0]   byte_t;
    typedef logic [31:0]  column_t;
    typedef logic [127:0] state_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MIX  = 2'd1,
        DONE = 2'd2
    } fsm_state_t;

    // Multiply by x in GF(2^8), reducing when the top bit falls out
    function automatic byte_t xtime(input byte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? GF_POLY : 8'h00);
    endfunction

endpackage : aes_pkg
`default_nettype wire

// File: rtl/inv_mix_column.sv
`default_nettype none
// ============================================================================
// Module      : inv_mix_column
// Description : Combinational InvMixColumns on one 32-bit state column.
//               Byte 0 of the column is the most significant byte.
// Revision    : 1.0 - initial release
// ============================================================================
module inv_mix_column
    import aes_pkg::*;
(
    input  column_t i_col,
    output column_t o_col
);

    byte_t w_a  [4];
    byte_t w_x2 [4];
    byte_t w_x4 [4];
    byte_t w_x8 [4];
    byte_t w_m9 [4];
    byte_t w_mb [4];
    byte_t w_md [4];
    byte_t w_me [4];

    // Build the 9/b/d/e multiples of every byte from a shared xtime chain
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            w_a[r]  = i_col[31-8*r -: 8];
            w_x2[r] = xtime(w_a[r]);
            w_x4[r] = xtime(w_x2[r]);
            w_x8[r] = xtime(w_x4[r]);
            w_m9[r] = w_x8[r] ^ w_a[r];
            w_mb[r] = w_x8[r] ^ w_x2[r] ^ w_a[r];
            w_md[r] = w_x8[r] ^ w_x4[r] ^ w_a[r];
            w_me[r] = w_x8[r] ^ w_x4[r] ^ w_x2[r];
        end
    end

    // Each output row uses the coefficient vector {0e,0b,0d,09} rotated by the row
    assign o_col = {
        w_me[0] ^ w_mb[1] ^ w_md[2] ^ w_m9[3],
        w_m9[0] ^ w_me[1] ^ w_mb[2] ^ w_md[3],
        w_md[0] ^ w_m9[1] ^ w_me[2] ^ w_mb[3],
        w_mb[0] ^ w_md[1] ^ w_m9[2] ^ w_me[3]
    };

endmodule : inv_mix_column
`default_nettype wire

// File: rtl/inv_add_round_mix.sv
`default_nettype none
// ============================================================================
// Module      : inv_add_round_mix
// Description : Decryption round stage after inv_sub_bytes: AddRoundKey then
//               InvMixColumns (skipped on the final round), with valid/ready
//               handshakes on both sides.
//               Build option INV_MIX_PARALLEL_EN: transform all four columns
//               in one cycle instead of one column per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module inv_add_round_mix
    import aes_pkg::*;
#(
    parameter int COLS = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state_in,
    input  logic [127:0] round_key,
    input  logic         skip_mix,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out
);

    // AES has exactly four columns; any other value is a configuration error
    if (COLS != 4) begin : g_cols_check
        $error("inv_add_round_mix: COLS must be 4");
    end

    fsm_state_t          state_q, state_d;
    logic [1:0]          col_cnt_q, col_cnt_d;
    column_t [COLS-1:0]  work_q, work_d;
    logic                w_accept;

    assign w_accept = in_valid & in_ready;

`ifdef INV_MIX_PARALLEL_EN
    column_t [COLS-1:0]  w_mixed;

    for (genvar c = 0; c < COLS; c++) begin : g_mix
        inv_mix_column u_inv_mix_column (
            .i_col (work_q[c]),
            .o_col (w_mixed[c])
        );
    end
`else
    // Packed index COLS-1 holds column 0 (MSBs), so the column counter is mirrored
    logic [1:0]          w_col_idx;
    column_t             w_col_mixed;
    logic                w_last_col;

    assign w_col_idx  = 2'(COLS - 1) - col_cnt_q;
    assign w_last_col = (col_cnt_q == 2'(COLS - 1));

    inv_mix_column u_inv_mix_column (
        .i_col (work_q[w_col_idx]),
        .o_col (w_col_mixed)
    );
`endif

    // State, column counter and working state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            col_cnt_q <= '0;
            work_q    <= '0;
        end else begin
            state_q   <= state_d;
            col_cnt_q <= col_cnt_d;
            work_q    <= work_d;
        end
    end

    // Next-state logic: accept, transform, then hold until the result is taken
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (w_accept) begin
                    state_d = skip_mix ? DONE : MIX;
                end
            end
            MIX: begin
`ifdef INV_MIX_PARALLEL_EN
                state_d = DONE;
`else
                if (w_last_col) begin
                    state_d = DONE;
                end
`endif
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath: key addition on accept, column replacement while mixing
    always_comb begin
        work_d    = work_q;
        col_cnt_d = col_cnt_q;
        case (state_q)
            IDLE: begin
                if (w_accept) begin
                    work_d    = state_in ^ round_key;
                    col_cnt_d = '0;
                end
            end
            MIX: begin
`ifdef INV_MIX_PARALLEL_EN
                work_d    = w_mixed;
                col_cnt_d = '0;
`else
                work_d[w_col_idx] = w_col_mixed;
                col_cnt_d         = w_last_col ? 2'd0 : col_cnt_q + 2'd1;
`endif
            end
            default: ;
        endcase
    end

    // Handshake outputs depend only on the registered state
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        state_out = work_q;
    end

endmodule : inv_add_round_mix
`default_nettype wire

// File: tb/tb_inv_add_round_mix.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_inv_add_round_mix
// Description : Self-checking bench for inv_add_round_mix against a
//               behavioural AES InvMixColumns model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inv_add_round_mix;

`ifdef INV_MIX_PARALLEL_EN
    localparam int MIX_LAT  = 2;
    localparam int RST_WAIT = 0;
`else
    localparam int MIX_LAT  = 5;
    localparam int RST_WAIT = 2;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] state_in;
    logic [127:0] round_key;
    logic         skip_mix;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] state_out;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    inv_add_round_mix #(.COLS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .state_in  (state_in),
        .round_key (round_key),
        .skip_mix  (skip_mix),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .state_out (state_out)
    );

    // GF(2^8) product: carry-less multiply then polynomial long division by 0x11B
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p;
        p = '0;
        for (int i = 0; i < 8; i++)
            if (b[i]) p = p ^ (15'(a) << i);
        for (int i = 14; i >= 8; i--)
            if (p[i]) p = p ^ (15'h11B << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [127:0] ref_model(input logic [127:0] s, input logic [127:0] k,
                                               input logic skip);
        logic [127:0] x;
        logic [7:0]   coef [4];
        logic [7:0]   a [4];
        logic [7:0]   b;
        coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        x = s ^ k;
        if (skip) return x;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) a[r] = x[127-32*c-8*r -: 8];
            for (int r = 0; r < 4; r++) begin
                b = 8'h00;
                for (int j = 0; j < 4; j++) b = b ^ gmul(coef[(j - r + 4) % 4], a[j]);
                x[127-32*c-8*r -: 8] = b;
            end
        end
        return x;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One transaction: present, accept, wait for result, optionally stall, handshake
    task automatic do_txn(input logic [127:0] s, input logic [127:0] k, input logic sk,
                          input int hold, input bit scramble,
                          output logic [127:0] res, output int lat);
        int n = 0;
        in_valid  = 1'b1;
        state_in  = s;
        round_key = k;
        skip_mix  = sk;
        out_ready = 1'b0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (scramble) begin
            state_in  = rnd128();
            round_key = rnd128();
            skip_mix  = ~sk;
        end
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid || n >= 50) lat = -1;
        res = state_out;
        repeat (hold) begin
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        skip_mix  = 1'b0;
        state_in  = '0;
        round_key = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({in_ready, out_valid, state_out} !== {1'b1, 1'b0, 128'h0})
            $display("FAIL reset_state: in_ready=%b out_valid=%b state_out=%h, want 1 0 0",
                     in_ready, out_valid, state_out);
        else n_pass++;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_kat();
        logic [127:0] res;
        int           lat;
        logic [127:0] exp;
        exp = {32'hdb135345, 32'h01010101, 32'h01010101, 32'h01010101};
        do_txn({32'h8e4da1bc, 32'h01010101, 32'h01010101, 32'h01010101}, 128'h0, 1'b0,
               0, 1'b0, res, lat);
        n_checks++;
        if (res !== exp) $display("FAIL kat_result: got %h want %h", res, exp);
        else n_pass++;
        n_checks++;
        if (lat !== MIX_LAT) $display("FAIL kat_latency: got %0d want %0d", lat, MIX_LAT);
        else n_pass++;
    endtask

    task automatic test_final_round();
        logic [127:0] res;
        int           lat;
        do_txn(128'h00112233_44556677_8899aabb_ccddeeff,
               128'h00010203_04050607_08090a0b_0c0d0e0f, 1'b1, 0, 1'b0, res, lat);
        n_checks++;
        if (res !== 128'h00102030_40506070_8090a0b0_c0d0e0f0)
            $display("FAIL final_result: got %h want 00102030405060708090a0b0c0d0e0f0", res);
        else n_pass++;
        n_checks++;
        if (lat !== 1) $display("FAIL final_latency: got %0d want 1", lat);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [127:0] s, k, exp;
        int           n = 0;
        s = rnd128();
        k = rnd128();
        exp = ref_model(s, k, 1'b0);
        in_valid  = 1'b1;
        state_in  = s;
        round_key = k;
        skip_mix  = 1'b0;
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if ({out_valid, in_ready, state_out} !== {1'b1, 1'b0, exp})
                $display("FAIL bp_hold[%0d]: out_valid=%b in_ready=%b state_out=%h, want 1 0 %h",
                         i, out_valid, in_ready, state_out, exp);
            else n_pass++;
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_checks++;
        if ({in_ready, out_valid} !== 2'b10)
            $display("FAIL bp_release: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [127:0] sa, ka, sb, kb, ra, rb;
        logic         ska, skb;
        int           early = 0;
        int           n = 0;
        sa = rnd128(); ka = rnd128(); ska = 1'($urandom_range(0, 1));
        sb = rnd128(); kb = rnd128(); skb = 1'($urandom_range(0, 1));
        in_valid  = 1'b1;
        state_in  = sa;
        round_key = ka;
        skip_mix  = ska;
        out_ready = 1'b1;
        @(posedge clk); #1;
        state_in  = sb;
        round_key = kb;
        skip_mix  = skb;
        while (!out_valid && n < 40) begin
            if (in_ready) early++;
            @(posedge clk); #1;
            n++;
        end
        if (in_ready) early++;
        ra = state_out;
        n_checks++;
        if (early !== 0) $display("FAIL b2b_no_overlap: in_ready high %0d cycles, want 0", early);
        else n_pass++;
        n_checks++;
        if (ra !== ref_model(sa, ka, ska))
            $display("FAIL b2b_first: got %h want %h", ra, ref_model(sa, ka, ska));
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL b2b_ready_after_hs: got %b want 1", in_ready);
        else n_pass++;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_checks++;
        if (in_ready !== 1'b0) $display("FAIL b2b_second_accept: in_ready=%b want 0", in_ready);
        else n_pass++;
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        rb = state_out;
        n_checks++;
        if (rb !== ref_model(sb, kb, skb))
            $display("FAIL b2b_second: got %h want %h", rb, ref_model(sb, kb, skb));
        else n_pass++;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_mix();
        logic [127:0] s, k, res;
        int           lat;
        int           seen = 0;
        in_valid  = 1'b1;
        state_in  = rnd128();
        round_key = rnd128();
        skip_mix  = 1'b0;
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (RST_WAIT) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_checks++;
        if ({out_valid, in_ready, state_out} !== {1'b0, 1'b1, 128'h0})
            $display("FAIL rst_mid_mix: out_valid=%b in_ready=%b state_out=%h, want 0 1 0",
                     out_valid, in_ready, state_out);
        else n_pass++;
        repeat (8) begin
            if (out_valid) seen++;
            @(posedge clk); #1;
        end
        n_checks++;
        if (seen !== 0) $display("FAIL rst_no_valid: out_valid high %0d cycles, want 0", seen);
        else n_pass++;
        s = rnd128();
        k = rnd128();
        do_txn(s, k, 1'b0, 1, 1'b0, res, lat);
        n_checks++;
        if (res !== ref_model(s, k, 1'b0))
            $display("FAIL rst_recover: got %h want %h", res, ref_model(s, k, 1'b0));
        else n_pass++;
        n_checks++;
        if (lat !== MIX_LAT) $display("FAIL rst_recover_lat: got %0d want %0d", lat, MIX_LAT);
        else n_pass++;
    endtask

    task automatic test_input_change();
        logic [127:0] s, k, res;
        int           lat;
        for (int sk = 0; sk < 2; sk++) begin
            s = rnd128();
            k = rnd128();
            do_txn(s, k, 1'(sk), 2, 1'b1, res, lat);
            n_checks++;
            if (res !== ref_model(s, k, 1'(sk)))
                $display("FAIL input_change[%0d]: got %h want %h", sk, res, ref_model(s, k, 1'(sk)));
            else n_pass++;
            n_checks++;
            if (lat !== (sk == 1 ? 1 : MIX_LAT))
                $display("FAIL input_change_lat[%0d]: got %0d want %0d",
                         sk, lat, (sk == 1 ? 1 : MIX_LAT));
            else n_pass++;
        end
    endtask

    task automatic test_random();
        logic [127:0] s, k, res;
        logic         sk;
        int           lat;
        for (int i = 0; i < 16; i++) begin
            s  = rnd128();
            k  = rnd128();
            sk = 1'($urandom_range(0, 1));
            do_txn(s, k, sk, int'($urandom_range(0, 3)), 1'b0, res, lat);
            n_checks++;
            if (res !== ref_model(s, k, sk))
                $display("FAIL random_result[%0d]: got %h want %h", i, res, ref_model(s, k, sk));
            else n_pass++;
            n_checks++;
            if (lat !== (sk ? 1 : MIX_LAT))
                $display("FAIL random_latency[%0d]: got %0d want %0d", i, lat, (sk ? 1 : MIX_LAT));
            else n_pass++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_kat();
        test_final_round();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_mix();
        test_input_change();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_inv_add_round_mix
`default_nettype wire
